// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes,
// FSM state encoding, ALU operation encodings and datapath mux selects.
package mc_ctrl_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BEQ,
    ST_JAL,
    ST_FAULT
  } state_t;

  // Coarse ALU intent chosen by the FSM; refined by the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  // Memory address source
  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  // Result bus source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  // ALU operand A source
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RS1      = 2'b10;
  // ALU operand B source
  localparam logic [1:0] SRCB_RS2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  // Immediate format
  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;

  // Immediate format is a pure function of the opcode
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU decoder: maps the FSM's ALUOp plus funct3/funct7/opcode bits to the
// ALU control code, and flags funct3 values outside the supported subset.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        op_b5,
  input  logic        funct7_b5,
  output alu_ctrl_t   alu_control,
  output logic        illegal
);

  // Decode ALU function; illegal depends on funct3 alone so DECODE can test it
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
      default:                        illegal = 1'b1;
    endcase
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM for a shared instruction/data memory and a
// single ALU. Memory states wait on mem_ready with a timeout into a sticky
// FAULT state. Optional MC_CTRL_PERF_EN adds cycle and retired-instruction
// counters.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrt,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrt,
  output logic       fault
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_state;
  logic              timeout;
  alu_op_t           alu_op;
  alu_ctrl_t         alu_ctrl;
  logic              funct_illegal;

  // Only funct7[5] distinguishes sub from add in this subset
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  mc_alu_decode u_alu_decode (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (Op[5]),
    .funct7_b5   (funct7[5]),
    .alu_control (alu_ctrl),
    .illegal     (funct_illegal)
  );

  assign mem_state = state_q inside {ST_FETCH, ST_MEMREAD, ST_MEMWRITE};
  // Last allowed wait cycle with memory still silent
  assign timeout   = mem_state && !mem_ready && (wait_cnt_q == WAIT_LAST);

  // State and wait-counter registers with synchronous reset
  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; mem_ready wins over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = funct_illegal ? ST_FAULT : ST_EXECR;
          OP_I:         state_d = funct_illegal ? ST_FAULT : ST_EXECI;
          OP_BEQ:       state_d = ST_BEQ;
          OP_JAL:       state_d = ST_JAL;
          default:      state_d = ST_FAULT;
        endcase
      end
      ST_MEMADR: state_d = (Op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD: begin
        if (mem_ready)    state_d = ST_MEMWB;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_MEMWRITE: begin
        if (mem_ready)    state_d = ST_FETCH;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_MEMWB, ST_ALUWB, ST_BEQ: state_d = ST_FETCH;
      ST_EXECR, ST_EXECI, ST_JAL: state_d = ST_ALUWB;
      ST_FAULT:                   state_d = ST_FAULT;
      default:                    state_d = ST_FAULT;
    endcase
  end

  // Wait counter: counts stalled memory cycles, restarts on any state change
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)           wait_cnt_d = '0;
    else if (mem_state && !mem_ready) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Coarse ALU intent per state
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state_q)
      ST_EXECR, ST_EXECI: alu_op = ALUOP_FUNCT;
      ST_BEQ:             alu_op = ALUOP_SUB;
      default:            alu_op = ALUOP_ADD;
    endcase
  end

  assign ALUControl = alu_ctrl;
  assign ImmSrc     = imm_src_of(Op);

  // Datapath controls decoded from the current state
  always_comb begin
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = ADR_PC;
    MemWrt    = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    RegWrt    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = ADR_ALUOUT;
      end
      ST_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        RegWrt    = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req = 1'b1;
        MemWrt  = 1'b1;
        AdrSrc  = ADR_ALUOUT;
      end
      ST_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
      end
      ST_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      ST_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrt    = 1'b1;
      end
      ST_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        PCWrite   = Zero;
      end
      ST_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default:  fault = 1'b1;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  // Perf counters advance outside FAULT; retirement is any entry into FETCH
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != ST_FAULT) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
      if (state_q != ST_FETCH && state_d == ST_FETCH)
        instret_cnt_d = instret_cnt_q + 1'b1;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  // Keeps CNT_W referenced in builds without the counters
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
